// File: rtl/minmax_pkg.sv
// Shared types for the min/max scan controller: FSM state encoding and index-width helper.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMP_MIN = 2'd1,
    CMP_MAX = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int idx_width(input int maxlen);
    return (maxlen > 1) ? $clog2(maxlen) : 1;
  endfunction

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator shared by the scan controller; purely combinational.
module comparator #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         smaller,
  output logic         greater,
  output logic         equal
);

  assign smaller = (a < b);
  assign greater = (a > b);
  assign equal   = (a == b);

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Frame min/max scanner: one shared comparator, one sample every 3 clocks, first-occurrence
// indices, valid/ready input and result ports.
module minmax_scan_ctrl
  import minmax_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int MAXLEN = 16,
  localparam int IDXW   = idx_width(MAXLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic            in_last,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N-1:0]    min_val,
  output logic [N-1:0]    max_val,
  output logic [IDXW-1:0] min_idx,
  output logic [IDXW-1:0] max_idx,
  output logic [IDXW:0]   count,
  output logic            overflow
);

  localparam logic [IDXW:0] MAXCNT = (IDXW+1)'(MAXLEN);
  localparam logic [IDXW:0] ONECNT = (IDXW+1)'(1);

  state_t          state_q, state_d;
  logic [N-1:0]    s_q, s_d;
  logic            l_q, l_d;
  logic [N-1:0]    min_val_q, min_val_d;
  logic [N-1:0]    max_val_q, max_val_d;
  logic [IDXW-1:0] min_idx_q, min_idx_d;
  logic [IDXW-1:0] max_idx_q, max_idx_d;
  logic [IDXW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic [N-1:0]    cmp_a, cmp_b;
  logic            cmp_smaller, cmp_greater, cmp_equal;
  logic [IDXW:0]   count_inc;
  logic            accept;

  comparator #(.N(N)) u_cmp (
    .a       (cmp_a),
    .b       (cmp_b),
    .smaller (cmp_smaller),
    .greater (cmp_greater),
    .equal   (cmp_equal)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign res_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + ONECNT;

  assign min_val  = min_val_q;
  assign max_val  = max_val_q;
  assign min_idx  = min_idx_q;
  assign max_idx  = max_idx_q;
  assign count    = count_q;
  assign overflow = overflow_q;

  // Operands are parked at zero outside the compare states so the comparator stays quiet.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    case (state_q)
      CMP_MIN: begin
        cmp_a = s_q;
        cmp_b = min_val_q;
      end
      CMP_MAX: begin
        cmp_a = s_q;
        cmp_b = max_val_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    l_d        = l_q;
    min_val_d  = min_val_q;
    max_val_d  = max_val_q;
    min_idx_d  = min_idx_q;
    max_idx_d  = max_idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          s_d = in_data;
          l_d = in_last;
          if (count_q == '0) begin
            min_val_d = in_data;
            max_val_d = in_data;
            min_idx_d = '0;
            max_idx_d = '0;
            count_d   = ONECNT;
            if (in_last || (MAXCNT == ONECNT)) begin
              state_d    = DONE;
              overflow_d = !in_last;
            end
          end else begin
            state_d = CMP_MIN;
          end
        end
      end
      CMP_MIN: begin
        // Strict compare: a tie keeps the earlier index.
        if (cmp_smaller && !cmp_equal) begin
          min_val_d = s_q;
          min_idx_d = count_q[IDXW-1:0];
        end
        state_d = CMP_MAX;
      end
      CMP_MAX: begin
        if (cmp_greater && !cmp_equal) begin
          max_val_d = s_q;
          max_idx_d = count_q[IDXW-1:0];
        end
        count_d = count_inc;
        if (l_q || (count_inc == MAXCNT)) begin
          state_d    = DONE;
          overflow_d = !l_q;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (res_ready) begin
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      l_q        <= 1'b0;
      min_val_q  <= '0;
      max_val_q  <= '0;
      min_idx_q  <= '0;
      max_idx_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      l_q        <= l_d;
      min_val_q  <= min_val_d;
      max_val_q  <= max_val_d;
      min_idx_q  <= min_idx_d;
      max_idx_q  <= max_idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Randomized bench for minmax_scan_ctrl: a frame-level reference model scores every result,
// with literal expectations pinning the directed frames.
module tb_minmax_scan_ctrl;

  localparam int N      = 4;
  localparam int MAXLEN = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_data;
  logic            in_last;
  logic            res_valid;
  logic            res_ready;
  logic [N-1:0]    min_val;
  logic [N-1:0]    max_val;
  logic [IDXW-1:0] min_idx;
  logic [IDXW-1:0] max_idx;
  logic [IDXW:0]   count;
  logic            overflow;

  minmax_scan_ctrl #(.N(N), .MAXLEN(MAXLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .min_val   (min_val),
    .max_val   (max_val),
    .min_idx   (min_idx),
    .max_idx   (max_idx),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mn;
    int mni;
    int mx;
    int mxi;
    int cnt;
    int ovf;
  } res_t;

  res_t exp_q[$];
  res_t got[$];
  int   frame[$];

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int due_cyc  = -1;
  int cmp_left = 0;
  int sent     = 0;
  int accepted = 0;
  bit hold_ready = 1'b0;
  bit prev_rv = 1'b0;
  bit prev_rr = 1'b0;
  int prev_bundle = 0;
  int bundle;

  assign bundle = int'({min_val, max_val, min_idx, max_idx, count, overflow});

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain scan of the frame, strict compares keep first occurrences.
  function automatic res_t summarize(input int q[$], input int ovf);
    res_t r;
    r.mn = q[0]; r.mni = 0; r.mx = q[0]; r.mxi = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] < r.mn) begin r.mn = q[i]; r.mni = i; end
      if (q[i] > r.mx) begin r.mx = q[i]; r.mxi = i; end
    end
    r.cnt = q.size();
    r.ovf = ovf;
    return r;
  endfunction

  // Monitor/compare process: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      frame.delete();
      exp_q.delete();
      cmp_left = 0;
      due_cyc  = -1;
      prev_rv  = 1'b0;
      prev_rr  = 1'b0;
    end else begin
      if (cmp_left > 0) begin
        check("in_ready_low_in_cmp", int'(in_ready), 0);
        cmp_left--;
      end
      if (res_valid) check("in_ready_low_in_done", int'(in_ready), 0);
      if (res_valid && !prev_rv) check("result_latency_cycle", cyc, due_cyc);
      if (res_valid && prev_rv && !prev_rr) check("result_stable_while_held", bundle, prev_bundle);
      if (res_valid && res_ready) begin
        res_t a;
        a.mn = int'(min_val); a.mni = int'(min_idx); a.mx = int'(max_val);
        a.mxi = int'(max_idx); a.cnt = int'(count); a.ovf = int'(overflow);
        got.push_back(a);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("min_val", a.mn, e.mn);
          check("min_idx", a.mni, e.mni);
          check("max_val", a.mx, e.mx);
          check("max_idx", a.mxi, e.mxi);
          check("count", a.cnt, e.cnt);
          check("overflow", a.ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) begin
        bit was_first;
        accepted++;
        was_first = (frame.size() == 0);
        frame.push_back(int'(in_data));
        if (!was_first) cmp_left = 2;
        if (in_last || frame.size() == MAXLEN) begin
          exp_q.push_back(summarize(frame, in_last ? 0 : 1));
          frame.delete();
          due_cyc = cyc + (was_first ? 1 : 3);
        end
      end
      prev_rv     = res_valid;
      prev_rr     = res_ready;
      prev_bundle = bundle;
    end
  end

  // Result consumer: random back-pressure unless the main sequence holds it off.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int d, input bit last);
    int gap;
    bit ok;
    gap = $urandom_range(0, 2);
    ok  = 1'b0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = 4'(d);
    in_last  = last;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    in_last  = 1'($urandom);
    sent++;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_results(input int n);
    for (int w = 0; w < 400; w++) begin
      if (got.size() >= n) break;
      @(negedge clk);
    end
    check("result_arrived", int'(got.size() >= n), 1);
  endtask

  task automatic check_res(input string tag, input int k, input int mn, input int mni,
                           input int mx, input int mxi, input int cnt, input int ovf);
    if (k >= got.size()) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      check({tag, "_min"}, got[k].mn, mn);
      check({tag, "_min_idx"}, got[k].mni, mni);
      check({tag, "_max"}, got[k].mx, mx);
      check({tag, "_max_idx"}, got[k].mxi, mxi);
      check({tag, "_count"}, got[k].cnt, cnt);
      check({tag, "_overflow"}, got[k].ovf, ovf);
    end
  endtask

  initial begin
    int base;
    int nres;
    int snap;
    bit seen;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_res_valid", int'(res_valid), 0);
    check("reset_outputs", bundle, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset mid-frame after two samples.
    send(6, 1'b0);
    send(10, 1'b0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_in_ready", int'(in_ready), 0);
    check("midframe_reset_res_valid", int'(res_valid), 0);
    check("midframe_reset_outputs", bundle, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    base = got.size();
    send(5, 1'b0); send(3, 1'b0); send(12, 1'b0); send(9, 1'b1);
    wait_results(base + 1);
    check_res("frame_5_3_12_9", base, 3, 1, 12, 2, 4, 0);

    base = got.size();
    send(7, 1'b0); send(7, 1'b0); send(2, 1'b0); send(15, 1'b0); send(2, 1'b0); send(15, 1'b1);
    wait_results(base + 1);
    check_res("frame_ties", base, 2, 2, 15, 3, 6, 0);

    base = got.size();
    send(13, 1'b1);
    wait_results(base + 1);
    check_res("single_sample", base, 13, 0, 13, 0, 1, 0);

    // Hold the result off for 10 cycles.
    base = got.size();
    hold_ready = 1'b1;
    send(4, 1'b0); send(1, 1'b0); send(8, 1'b1);
    seen = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("held_result_valid", int'(seen), 1);
    snap = bundle;
    repeat (10) begin
      @(negedge clk);
      check("held_in_ready", int'(in_ready), 0);
      check("held_res_valid", int'(res_valid), 1);
      check("held_outputs", bundle, snap);
    end
    hold_ready = 1'b0;
    wait_results(base + 1);
    check_res("held_frame", base, 1, 1, 8, 2, 3, 0);

    // Overflow: 16 samples without last, then a fresh single-sample frame.
    base = got.size();
    for (int v = 0; v < 16; v++) send(v, 1'b0);
    send(9, 1'b1);
    wait_results(base + 2);
    check_res("overflow_frame", base, 0, 0, 15, 15, 16, 1);
    check_res("after_overflow", base + 1, 9, 0, 9, 0, 1, 0);

    // Random frames, some longer than MAXLEN.
    base = got.size();
    nres = 0;
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 20);
      nres += (len + MAXLEN - 1) / MAXLEN;
      for (int i = 0; i < len; i++) send(int'($urandom_range(0, 15)), i == len - 1);
    end
    wait_results(base + nres);
    repeat (3) @(negedge clk);
    check("no_pending_expected", exp_q.size(), 0);
    check("samples_accepted", accepted, sent);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
